ps2_rx_decoder: RTL and testbench

PS2_RX_DECODER -- requirements
Module: ps2_rx_decoder

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_sync_edge.sv | 42 ++++
 rtl/ps2_rx_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_rx_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 receive decoder:
//   - ps2_state_e           : frame receiver state encoding
//   - PS2_PREFIX_EXT/BRK    : scan-code prefixes for extended keys and releases
//   - PS2_DEFAULT_KEY_CODES : default tracked make codes; entry i sits at
//                             bits [8i+7:8i], so index 0 is 8'h76
//   - ps2_parity_ok()       : odd-parity check over data byte plus parity bit
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // Key list in index order 76, 1D, 1B, 29 (index 0 in the low byte).
    localparam logic [31:0] PS2_DEFAULT_KEY_CODES = {8'h29, 8'h1B, 8'h1D, 8'h76};

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd
    // number of ones.
    function automatic logic ps2_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ----------------------------------------------------------------------------
// ps2_sync_edge
// Brings the raw PS/2 clock and data lines into the system clock domain with
// two-flop synchronisers and detects falling edges of the synchronised clock.
// Ports:
//   clk_i     in  system clock
//   rst_ni    in  asynchronous active-low reset (flops reset to idle-high)
//   ps2_clk_i in  raw PS/2 clock
//   ps2_dat_i in  raw PS/2 data
//   clk_fall  out one-cycle strobe: synced clock was 1 last cycle, 0 now
//   dat_s     out synchronised PS/2 data, aligned with clk_fall
// ----------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_fall,
    output logic dat_s
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Reset to 1 (the idle bus level) so releasing reset never fakes a fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// ----------------------------------------------------------------------------
// ps2_rx_decoder
// Receives PS/2 keyboard frames (start, 8 data LSB first, odd parity, stop),
// folds E0/F0 prefixes into EXTENDED/BREAK flags, reports errors and tracks
// the held state of a configurable set of keys.
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   TIMEOUT_US max gap between PS/2 clock falls inside a frame
//   NUM_KEYS   number of tracked keys
//   KEY_CODES  packed make codes, entry i at [8i+7:8i]
// Ports:
//   CLK        in  system clock
//   RESETN     in  asynchronous active-low reset
//   PS2_CLK    in  raw PS/2 clock (asynchronous)
//   PS2_DAT    in  raw PS/2 data (asynchronous)
//   DATA_OUT   out last accepted non-prefix scan code (held)
//   DATA_VALID out one-cycle pulse when DATA_OUT/EXTENDED/BREAK update
//   EXTENDED   out code was preceded by E0 (held)
//   BREAK      out code was preceded by F0 (held)
//   PARITY_ERR out one-cycle pulse on parity failure
//   FRAME_ERR  out one-cycle pulse on bad stop bit or inter-bit timeout
//   KEY_DOWN   out level per tracked key, high while held
// ----------------------------------------------------------------------------
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int                      CLK_HZ     = 50_000_000,
    parameter int                      TIMEOUT_US = 200,
    parameter int                      NUM_KEYS   = 4,
    parameter logic [8*NUM_KEYS-1:0]   KEY_CODES  = PS2_DEFAULT_KEY_CODES
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [7:0]          DATA_OUT,
    output logic                DATA_VALID,
    output logic                EXTENDED,
    output logic                BREAK,
    output logic                PARITY_ERR,
    output logic                FRAME_ERR,
    output logic [NUM_KEYS-1:0] KEY_DOWN
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TMO_W-1:0] TMO_TERM = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

    // Saturating increment: the counter parks at its maximum instead of
    // wrapping back to zero.
    function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] v);
        return (v == TMO_MAX) ? v : v + TMO_W'(1);
    endfunction

    logic clk_fall;
    logic dat_s;

    ps2_sync_edge u_sync (
        .clk_i     (CLK),
        .rst_ni    (RESETN),
        .ps2_clk_i (PS2_CLK),
        .ps2_dat_i (PS2_DAT),
        .clk_fall  (clk_fall),
        .dat_s     (dat_s)
    );

    ps2_state_e           state_q,  state_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic [7:0]           shift_q,  shift_d;
    logic                 par_q,    par_d;
    logic [TMO_W-1:0]     tmo_q,    tmo_d;
    logic                 ext_q,    ext_d;
    logic                 brk_q,    brk_d;
    logic [7:0]           data_q,   data_d;
    logic                 exto_q,   exto_d;
    logic                 brko_q,   brko_d;
    logic                 valid_q,  valid_d;
    logic                 perr_q,   perr_d;
    logic                 ferr_q,   ferr_d;
    logic [NUM_KEYS-1:0]  key_q,    key_d;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            data_q   <= '0;
            exto_q   <= 1'b0;
            brko_q   <= 1'b0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            data_q   <= data_d;
            exto_q   <= exto_d;
            brko_q   <= brko_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            key_q    <= key_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tmo_d    = tmo_sat_inc(tmo_q);
        ext_d    = ext_q;
        brk_d    = brk_q;
        data_d   = data_q;
        exto_d   = exto_q;
        brko_d   = brko_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        key_d    = key_q;

        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end

        if (clk_fall) begin
            // A fall always restarts the gap timer, so a fall landing on the
            // terminal count takes priority over the timeout below.
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_s) begin
                        // Bad stop bit outranks a parity failure.
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (!ps2_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        exto_d  = ext_q;
                        brko_d  = brk_q;
                        valid_d = 1'b1;
                        ext_d   = 1'b0;
                        brk_d   = 1'b0;
                        // Extended codes share make values with normal keys
                        // (e.g. E0 75 vs 75), so they never touch KEY_DOWN.
                        if (!ext_q) begin
                            for (int i = 0; i < NUM_KEYS; i++) begin
                                if (shift_q == KEY_CODES[8*i +: 8]) begin
                                    key_d[i] = ~brk_q;
                                end
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_TERM) begin
            // Bus stalled mid-frame: drop the partial byte and any prefixes.
            ferr_d   = 1'b1;
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            shift_d  = '0;
            ext_d    = 1'b0;
            brk_d    = 1'b0;
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign EXTENDED   = exto_q;
    assign BREAK      = brko_q;
    assign PARITY_ERR = perr_q;
    assign FRAME_ERR  = ferr_q;
    assign KEY_DOWN   = key_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_rx_decoder
// Self-checking bench for ps2_rx_decoder. A scaled clock (1 MHz nominal,
// 100 us timeout -> 100 cycles) keeps the timeout scenario short. A scan-code
// level reference model tracks prefix flags, held outputs and key state.
// ----------------------------------------------------------------------------
module tb_ps2_rx_decoder;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       EXTENDED;
    logic       BREAK;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic [3:0] KEY_DOWN;

    ps2_rx_decoder #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (100),
        .NUM_KEYS   (4),
        .KEY_CODES  ({8'h29, 8'h1B, 8'h1D, 8'h76})
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .PS2_CLK    (PS2_CLK),
        .PS2_DAT    (PS2_DAT),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .EXTENDED   (EXTENDED),
        .BREAK      (BREAK),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .KEY_DOWN   (KEY_DOWN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Pulse-cycle counters sampled on the inactive edge.
    int n_valid = 0;
    int n_perr  = 0;
    int n_ferr  = 0;

    always @(negedge CLK) begin
        if (RESETN) begin
            if (DATA_VALID) n_valid++;
            if (PARITY_ERR) n_perr++;
            if (FRAME_ERR)  n_ferr++;
        end
    end

    // Reference model state.
    logic [7:0] key_tab [4] = '{8'h76, 8'h1D, 8'h1B, 8'h29};
    bit         m_ext, m_brk;
    logic [3:0] m_keys;
    logic [7:0] m_data;
    bit         m_dext, m_dbrk;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_keys = '0; m_data = '0; m_dext = 0; m_dbrk = 0;
    endtask

    // Apply one received frame to the model; return expected pulses.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop,
                               output int ev, output int ep, output int ef);
        ev = 0; ep = 0; ef = 0;
        if (stop == 1'b0) begin
            ef = 1; m_ext = 0; m_brk = 0;
        end else if (($countones({b, par}) % 2) == 0) begin
            ep = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            ev = 1;
            m_data = b; m_dext = m_ext; m_dbrk = m_brk;
            if (!m_ext) begin
                for (int i = 0; i < 4; i++) begin
                    if (key_tab[i] == b) m_keys[i] = !m_brk;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Serialise n bits LSB first; data changes while PS2_CLK is high.
    task automatic send_bits(input logic [10:0] bits, input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            PS2_DAT = bits[i];
            repeat (half) @(negedge CLK);
            PS2_CLK = 1'b0;
            repeat (half) @(negedge CLK);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag, input int v0, input int p0, input int f0,
                                 input int ev, input int ep, input int ef);
        n_checks++;
        if ((n_valid - v0) !== ev) $display("FAIL %s valid_cycles got %0d want %0d", tag, n_valid - v0, ev);
        else n_pass++;
        n_checks++;
        if ((n_perr - p0) !== ep) $display("FAIL %s parity_err_cycles got %0d want %0d", tag, n_perr - p0, ep);
        else n_pass++;
        n_checks++;
        if ((n_ferr - f0) !== ef) $display("FAIL %s frame_err_cycles got %0d want %0d", tag, n_ferr - f0, ef);
        else n_pass++;
        n_checks++;
        if ({DATA_OUT, EXTENDED, BREAK} !== {m_data, m_dext, m_dbrk})
            $display("FAIL %s data/ext/brk got %02h/%0b/%0b want %02h/%0b/%0b",
                     tag, DATA_OUT, EXTENDED, BREAK, m_data, m_dext, m_dbrk);
        else n_pass++;
        n_checks++;
        if (KEY_DOWN !== m_keys) $display("FAIL %s key_down got %b want %b", tag, KEY_DOWN, m_keys);
        else n_pass++;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                         input int half, input string tag);
        int v0, p0, f0, ev, ep, ef;
        logic par, stop;
        par  = bad_par ? ^b : ~^b;
        stop = ~bad_stop;
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bits({stop, par, b, 1'b0}, 11, half);
        repeat (6) @(negedge CLK);
        model_frame(b, par, stop, ev, ep, ef);
        check_outputs(tag, v0, p0, f0, ev, ep, ef);
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({DATA_OUT, EXTENDED, BREAK, DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN} !== 16'h0)
            $display("FAIL reset_outputs got %h want 0",
                     {DATA_OUT, EXTENDED, BREAK, DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN});
        else n_pass++;
        RESETN = 1'b1;
        repeat (5) @(negedge CLK);
        n_checks++;
        if ({DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN} !== 7'h0)
            $display("FAIL post_reset_quiet got %h want 0", {DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN});
        else n_pass++;
    endtask

    task automatic test_make();
        frame(8'h1D, 0, 0, 10, "make_1D");
    endtask

    task automatic test_break();
        frame(8'hF0, 0, 0, 10, "brk_prefix");
        frame(8'h1D, 0, 0, 10, "break_1D");
    endtask

    task automatic test_extended();
        frame(8'hE0, 0, 0, 10, "ext_prefix");
        frame(8'hF0, 0, 0, 10, "ext_brk_prefix");
        frame(8'h75, 0, 0, 10, "ext_break_75");
        frame(8'hE0, 0, 0, 10, "ext_prefix2");
        frame(8'h76, 0, 0, 10, "ext_make_76");
    endtask

    task automatic test_parity();
        frame(8'h76, 1, 0, 10, "parity_bad_76");
        frame(8'h76, 0, 0, 10, "parity_good_76");
        frame(8'hF0, 0, 0, 10, "both_err_prefix");
        frame(8'h1B, 1, 1, 10, "both_err_1B");
        frame(8'h1B, 0, 0, 10, "after_both_1B");
    endtask

    task automatic test_idle_noise();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_bits(11'h7FF, 1, 10);
        repeat (6) @(negedge CLK);
        n_checks++;
        if ((n_perr - p0) + (n_ferr - f0) !== 0)
            $display("FAIL idle_fall_no_err got %0d want 0", (n_perr - p0) + (n_ferr - f0));
        else n_pass++;
        frame(8'h29, 0, 0, 10, "after_idle_29");
    endtask

    task automatic test_timeout();
        int v0, p0, f0;
        frame(8'hF0, 0, 0, 10, "tmo_brk_prefix");
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bits({7'h5A, 4'b1010}, 5, 10);
        repeat (250) @(negedge CLK);
        m_ext = 0; m_brk = 0;
        check_outputs("timeout", v0, p0, f0, 0, 0, 1);
        frame(8'h29, 0, 0, 10, "after_tmo_29");
        frame(8'h1D, 0, 0, 45, "slow_1D");
    endtask

    task automatic test_reset_midframe();
        frame(8'h76, 0, 0, 10, "pre_rst_76");
        send_bits(11'h0AA, 5, 10);
        RESETN = 1'b0;
        #1;
        n_checks++;
        if ({DATA_OUT, EXTENDED, BREAK, DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN} !== 16'h0)
            $display("FAIL midframe_reset got %h want 0",
                     {DATA_OUT, EXTENDED, BREAK, DATA_VALID, PARITY_ERR, FRAME_ERR, KEY_DOWN});
        else n_pass++;
        model_reset();
        repeat (3) @(negedge CLK);
        PS2_DAT = 1'b1;
        RESETN  = 1'b1;
        repeat (5) @(negedge CLK);
        frame(8'h1B, 0, 0, 10, "after_rst_1B");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r;
        bit bp, bs;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r < 7) b = key_tab[$urandom_range(0, 3)];
            else            b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            frame(b, bp, bs, $urandom_range(4, 12), $sformatf("rand%0d_%02h", k, b));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make();
        test_break();
        test_extended();
        test_parity();
        test_idle_noise();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
